pyldin_mem_ctrl: RTL and testbench
==================================

PYLDIN_MEM_CTRL -- requirements
Module: pyldin_mem_ctrl

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset.
REQ-002 Parameter: WP_EN, default 1, meaning write-protect E000-FFFF (excluding register page) when 1.
REQ-003 Port: clk  in  1  system clock, all state on rising edge.
REQ-004 Port: rst_n  in  1  asynchronous active-low reset.
REQ-005 Port: cpu_addr  in  16  CPU address, held stable while cpu_vma high.
REQ-006 Port: cpu_rw  in  1  1=read, 0=write.
REQ-007 Port: cpu_vma  in  1  request valid, sampled only in IDLE.
REQ-008 Port: cpu_wdata  in  8  write data.
REQ-009 Port: cpu_rdata  out  8  read data, valid while cpu_ready high.
REQ-010 Port: cpu_ready  out  1  one-cycle completion pulse.
REQ-011 Port: ram_cs, ram_rw, ram_read  out  1 each  RAM strobes (ram_rw 0 = write).
REQ-012 Port: ram_page  out  3  current bank number.
REQ-013 Port: ram_addr  out  19  physical byte address.
REQ-014 Port: ram_wdata  out  8  RAM write data.
REQ-015 Port: ram_rdata  in  8  RAM registered read data, one cycle after cs&read.

Function
REQ-016 All outputs SHALL be registered.
REQ-017 The FSM SHALL have states IDLE, WR, RD_ISSUE, RD_WAIT, DONE.
REQ-018 Internal register bank_reg[7:0] at CPU address E6F0: bits[2:0] bank, bit7 window enable, bits[6:3] read as 0.
REQ-019 Mapping SHALL be: 0000-BFFF -> phys {3'b000,cpu_addr}; C000-DFFF with enable=1 -> phys 0x10000 + bank*0x2000 + cpu_addr[12:0]; C000-DFFF with enable=0 and E000-FFFF -> phys {3'b000,cpu_addr}.
REQ-020 ram_page SHALL equal bank_reg[2:0] at all times.
REQ-021 IDLE with cpu_vma=1 and cpu_addr=E6F0: write loads bank_reg from cpu_wdata; read loads cpu_rdata with bank_reg masked; next state DONE; no RAM strobe.
REQ-022 IDLE with cpu_vma=1, cpu_rw=0, other address: next state WR; in WR ram_cs=1, ram_rw=0, ram_read=0, ram_addr/ram_wdata driven; then DONE.
REQ-023 Write to E000-FFFF (not E6F0) with WP_EN=1 SHALL go to DONE without asserting ram_cs.
REQ-024 IDLE with cpu_vma=1, cpu_rw=1: RD_ISSUE (ram_cs=1, ram_read=1, ram_rw=1) -> RD_WAIT (strobes 0) -> capture ram_rdata into cpu_rdata at end of RD_WAIT -> DONE.
REQ-025 In DONE cpu_ready=1 for exactly one cycle, then IDLE unconditionally; cpu_vma ignored outside IDLE.
REQ-026 Latency from accepting edge to cpu_ready high: register access 1 cycle, write 2 cycles, read 3 cycles.
REQ-027 ram_cs, ram_read SHALL be 0 and ram_rw SHALL be 1 in every state other than WR/RD_ISSUE.
REQ-028 A bank change SHALL take effect on the next accepted request; no request is split across banks.
REQ-029 cpu_rdata SHALL hold its last value until the next read completes.

Reset
REQ-030 Assertion of rst_n=0 at any time, including mid-access, SHALL immediately force state IDLE, bank_reg=0, cpu_ready=0, cpu_rdata=0, ram_cs=0, ram_read=0, ram_rw=1, ram_addr=0, ram_wdata=0.
REQ-031 After rst_n deasserts, the first request SHALL be accepted at the first rising edge with cpu_vma=1.

Verification
REQ-032 Write 0x5A to 0x1234 then read 0x1234 -> ram_cs write pulse at addr 0x01234; read returns 0x5A with cpu_ready 3 cycles after acceptance.
REQ-033 Write 0x83 to E6F0, read C005 -> ram_page=3, ram_addr=0x16005; read E6F0 returns 0x83 after 1 cycle, no ram_cs.
REQ-034 Write 0x03 (enable=0) to E6F0, read C005 -> ram_addr=0x0C005.
REQ-035 WP_EN=1, write 0xFF to F000 -> cpu_ready after 2 cycles, ram_cs never asserted; with WP_EN=0 -> ram write at 0x0F000.
REQ-036 Assert rst_n=0 during RD_WAIT -> all outputs at reset values same cycle, no cpu_ready; subsequent read completes normally.
REQ-037 cpu_vma held high through DONE -> exactly one access per IDLE acceptance, back-to-back reads separated by one IDLE cycle.

Source files
------------

// File: rtl/pyldin_mem_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : pyldin_mem_ctrl
// Description : Memory controller for an 8-bit CPU bus in front of a 512 KiB
//               synchronous RAM. Maps the 64 KiB CPU space onto a 19-bit
//               physical space. A 8 KiB window at C000-DFFF can be redirected
//               to one of eight banks above 0x10000. The window is selected by
//               a bank register at E6F0. E000-FFFF can be write-protected.
//               All outputs are registered.
// Revision    : 1.0  initial release
// ----------------------------------------------------------------------------
// Parameters
//   WP_EN      1 = writes to E000-FFFF (except E6F0) do not reach the RAM
// Ports
//   clk        system clock, all state changes on the rising edge
//   rst_n      asynchronous active-low reset
//   cpu_addr   CPU address, held stable while cpu_vma is high
//   cpu_rw     1 = read, 0 = write
//   cpu_vma    request valid; only looked at while idle
//   cpu_wdata  CPU write data
//   cpu_rdata  read data, valid while cpu_ready is high, held until next read
//   cpu_ready  one-cycle completion pulse
//   ram_cs     RAM chip select
//   ram_rw     RAM direction, 0 = write
//   ram_read   RAM read strobe
//   ram_page   currently selected bank (bank register bits [2:0])
//   ram_addr   19-bit physical byte address
//   ram_wdata  RAM write data
//   ram_rdata  RAM read data, registered by the RAM one cycle after cs&read
// ============================================================================
module pyldin_mem_ctrl #(
    parameter int unsigned WP_EN = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [15:0] cpu_addr,
    input  logic        cpu_rw,
    input  logic        cpu_vma,
    input  logic [7:0]  cpu_wdata,
    output logic [7:0]  cpu_rdata,
    output logic        cpu_ready,
    output logic        ram_cs,
    output logic        ram_rw,
    output logic        ram_read,
    output logic [2:0]  ram_page,
    output logic [18:0] ram_addr,
    output logic [7:0]  ram_wdata,
    input  logic [7:0]  ram_rdata
);

    // ------------------------------------------------------------------------
    // Constants
    // ------------------------------------------------------------------------
    localparam logic [15:0] c_BANK_REG_ADDR = 16'hE6F0;
    // Only the bank number and the window-enable bit are implemented.
    localparam logic [7:0]  c_BANK_REG_MASK = 8'h87;
    localparam logic [18:0] c_WINDOW_BASE   = 19'h10000;
    localparam logic [2:0]  c_SEG_WINDOW    = 3'b110;   // C000-DFFF
    localparam logic [2:0]  c_SEG_TOP       = 3'b111;   // E000-FFFF

    localparam int c_STATE_W = 3;

    typedef enum logic [c_STATE_W-1:0] {
        c_ST_IDLE     = 3'd0,
        c_ST_WR       = 3'd1,
        c_ST_RD_ISSUE = 3'd2,
        c_ST_RD_WAIT  = 3'd3,
        c_ST_DONE     = 3'd4
    } state_t;

    // ------------------------------------------------------------------------
    // State and registered outputs
    // ------------------------------------------------------------------------
    state_t      r_state_q, w_state_d;
    logic [7:0]  r_bank_q,  w_bank_d;
    logic [7:0]  r_rdata_q, w_rdata_d;
    logic        r_ready_q, w_ready_d;
    logic        r_cs_q,    w_cs_d;
    logic        r_rw_q,    w_rw_d;
    logic        r_read_q,  w_read_d;
    logic [18:0] r_addr_q,  w_addr_d;
    logic [7:0]  r_wdata_q, w_wdata_d;

    // ------------------------------------------------------------------------
    // Address decode
    // ------------------------------------------------------------------------
    logic        w_is_bank_reg;
    logic        w_in_window;
    logic        w_in_top;
    logic        w_wr_blocked;
    logic [18:0] w_phys_addr;

    assign w_is_bank_reg = (cpu_addr == c_BANK_REG_ADDR);
    assign w_in_window   = (cpu_addr[15:13] == c_SEG_WINDOW);
    assign w_in_top      = (cpu_addr[15:13] == c_SEG_TOP);

    // The window is translated with the bank value current at acceptance,
    // so a bank change only affects requests accepted after it completed.
    assign w_phys_addr = (w_in_window && r_bank_q[7])
                       ? (c_WINDOW_BASE
                          + {3'b000, r_bank_q[2:0], 13'd0}
                          + {6'd0, cpu_addr[12:0]})
                       : {3'b000, cpu_addr};

    generate
        if (WP_EN != 0) begin : g_wp_on
            // The bank register lives inside the protected page but must
            // stay writable; it is decoded ahead of this term anyway.
            assign w_wr_blocked = w_in_top & ~w_is_bank_reg;
        end else begin : g_wp_off
            assign w_wr_blocked = 1'b0;
        end
    endgenerate

    // ------------------------------------------------------------------------
    // Next-state logic
    // The RAM strobes and cpu_ready are registered, so each is computed here
    // for the state being entered: the strobes are high exactly while the
    // FSM sits in WR or RD_ISSUE, and cpu_ready exactly while in DONE.
    // ------------------------------------------------------------------------
    always_comb begin
        w_state_d = r_state_q;
        w_bank_d  = r_bank_q;
        w_rdata_d = r_rdata_q;
        w_addr_d  = r_addr_q;
        w_wdata_d = r_wdata_q;
        w_ready_d = 1'b0;
        w_cs_d    = 1'b0;
        w_read_d  = 1'b0;
        w_rw_d    = 1'b1;

        case (r_state_q)
            c_ST_IDLE: begin
                if (cpu_vma) begin
                    if (w_is_bank_reg) begin
                        // Internal register: completes without a RAM cycle.
                        if (cpu_rw) begin
                            w_rdata_d = r_bank_q & c_BANK_REG_MASK;
                        end else begin
                            w_bank_d = cpu_wdata & c_BANK_REG_MASK;
                        end
                        w_state_d = c_ST_DONE;
                        w_ready_d = 1'b1;
                    end else if (!cpu_rw) begin
                        // A protected write still spends one cycle in WR so
                        // that every write has the same latency; it just
                        // never raises the chip select.
                        w_state_d = c_ST_WR;
                        if (!w_wr_blocked) begin
                            w_cs_d    = 1'b1;
                            w_rw_d    = 1'b0;
                            w_addr_d  = w_phys_addr;
                            w_wdata_d = cpu_wdata;
                        end
                    end else begin
                        w_state_d = c_ST_RD_ISSUE;
                        w_cs_d    = 1'b1;
                        w_read_d  = 1'b1;
                        w_addr_d  = w_phys_addr;
                    end
                end
            end

            c_ST_WR: begin
                w_state_d = c_ST_DONE;
                w_ready_d = 1'b1;
            end

            c_ST_RD_ISSUE: begin
                // RAM registers the data at the end of this cycle.
                w_state_d = c_ST_RD_WAIT;
            end

            c_ST_RD_WAIT: begin
                // RAM output is valid during this cycle; capture it so it
                // is presented together with cpu_ready.
                w_state_d = c_ST_DONE;
                w_ready_d = 1'b1;
                w_rdata_d = ram_rdata;
            end

            c_ST_DONE: begin
                // cpu_vma is deliberately ignored here, which guarantees one
                // IDLE cycle between consecutive accesses.
                w_state_d = c_ST_IDLE;
            end

            default: begin
                w_state_d = c_ST_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state_q <= c_ST_IDLE;
            r_bank_q  <= 8'h00;
            r_rdata_q <= 8'h00;
            r_ready_q <= 1'b0;
            r_cs_q    <= 1'b0;
            r_rw_q    <= 1'b1;
            r_read_q  <= 1'b0;
            r_addr_q  <= 19'd0;
            r_wdata_q <= 8'h00;
        end else begin
            r_state_q <= w_state_d;
            r_bank_q  <= w_bank_d;
            r_rdata_q <= w_rdata_d;
            r_ready_q <= w_ready_d;
            r_cs_q    <= w_cs_d;
            r_rw_q    <= w_rw_d;
            r_read_q  <= w_read_d;
            r_addr_q  <= w_addr_d;
            r_wdata_q <= w_wdata_d;
        end
    end

    // ------------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------------
    assign cpu_rdata = r_rdata_q;
    assign cpu_ready = r_ready_q;
    assign ram_cs    = r_cs_q;
    assign ram_rw    = r_rw_q;
    assign ram_read  = r_read_q;
    assign ram_page  = r_bank_q[2:0];
    assign ram_addr  = r_addr_q;
    assign ram_wdata = r_wdata_q;

endmodule

`default_nettype wire

// File: tb/tb_pyldin_mem_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_pyldin_mem_ctrl
// Description : Scoreboard bench for pyldin_mem_ctrl. Two instances share one
//               CPU stimulus stream: "_p" with write protection on, "_u"
//               with it off. Each has its own RAM model. A reference model
//               (address-map arithmetic plus associative memories) predicts
//               completions and RAM cycles into queues; monitors compare.
// Revision    : 1.0  initial release
// ============================================================================
module tb_pyldin_mem_ctrl;

    localparam int c_N_RANDOM = 300;
    localparam int c_TIMEOUT  = 12;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [15:0] r_cpu_addr;
    logic        r_cpu_rw;
    logic        r_cpu_vma;
    logic [7:0]  r_cpu_wdata;

    logic [7:0]  w_rdata_p, w_rdata_u;
    logic        w_ready_p, w_ready_u;
    logic        w_cs_p, w_cs_u, w_rw_p, w_rw_u, w_read_p, w_read_u;
    logic [2:0]  w_page_p, w_page_u;
    logic [18:0] w_addr_p, w_addr_u;
    logic [7:0]  w_wdata_p, w_wdata_u;
    logic [7:0]  r_ram_rdata_p = 8'h00;
    logic [7:0]  r_ram_rdata_u = 8'h00;

    int cyc      = 0;
    int n_checks = 0;
    int n_errors = 0;

    pyldin_mem_ctrl #(.WP_EN(1)) dut_p (
        .clk(clk), .rst_n(rst_n),
        .cpu_addr(r_cpu_addr), .cpu_rw(r_cpu_rw), .cpu_vma(r_cpu_vma),
        .cpu_wdata(r_cpu_wdata), .cpu_rdata(w_rdata_p), .cpu_ready(w_ready_p),
        .ram_cs(w_cs_p), .ram_rw(w_rw_p), .ram_read(w_read_p),
        .ram_page(w_page_p), .ram_addr(w_addr_p), .ram_wdata(w_wdata_p),
        .ram_rdata(r_ram_rdata_p)
    );

    pyldin_mem_ctrl #(.WP_EN(0)) dut_u (
        .clk(clk), .rst_n(rst_n),
        .cpu_addr(r_cpu_addr), .cpu_rw(r_cpu_rw), .cpu_vma(r_cpu_vma),
        .cpu_wdata(r_cpu_wdata), .cpu_rdata(w_rdata_u), .cpu_ready(w_ready_u),
        .ram_cs(w_cs_u), .ram_rw(w_rw_u), .ram_read(w_read_u),
        .ram_page(w_page_u), .ram_addr(w_addr_u), .ram_wdata(w_wdata_u),
        .ram_rdata(r_ram_rdata_u)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // ------------------------------------------------------------------------
    // RAM models (synchronous, registered read data)
    // ------------------------------------------------------------------------
    bit [7:0] mem_p [0:524287];
    bit [7:0] mem_u [0:524287];

    always @(posedge clk) begin
        if (w_cs_p && w_read_p) r_ram_rdata_p <= mem_p[w_addr_p];
        if (w_cs_p && !w_rw_p)  mem_p[w_addr_p] <= w_wdata_p;
    end

    always @(posedge clk) begin
        if (w_cs_u && w_read_u) r_ram_rdata_u <= mem_u[w_addr_u];
        if (w_cs_u && !w_rw_u)  mem_u[w_addr_u] <= w_wdata_u;
    end

    // ------------------------------------------------------------------------
    // Reference model state and scoreboard queues
    // ------------------------------------------------------------------------
    bit [7:0] m_bank;
    bit [7:0] m_last_p, m_last_u;
    bit [7:0] m_mem_p [int];
    bit [7:0] m_mem_u [int];

    typedef struct {
        int       k;      // cycle count when the request was presented
        int       lat;    // cycles from accepting edge to cpu_ready
        bit [7:0] rd_p;
        bit [7:0] rd_u;
        bit [2:0] page;
    } rsp_t;

    typedef struct {
        int        cyc;   // cycle count at which the strobe must be seen
        bit        s_p;
        bit        s_u;
        bit        wr;
        bit [18:0] addr;
        bit [7:0]  wd;
    } op_t;

    rsp_t rsp_q [$];
    op_t  op_q  [$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Physical address from the memory map, using plain arithmetic.
    function automatic bit [18:0] ref_phys(input bit [15:0] a);
        int p;
        if (a >= 16'hC000 && a < 16'hE000 && m_bank[7])
            p = 'h10000 + int'(m_bank[2:0]) * 'h2000 + (int'(a) - 'hC000);
        else
            p = int'(a);
        return p[18:0];
    endfunction

    // ------------------------------------------------------------------------
    // Monitors
    // ------------------------------------------------------------------------
    always @(negedge clk) begin
        rsp_t e;
        if (w_ready_p || w_ready_u) begin
            if (rsp_q.size() == 0) begin
                chk("ready_unexpected", {30'd0, w_ready_p, w_ready_u}, 32'd0);
            end else begin
                e = rsp_q.pop_front();
                chk("ready_p", w_ready_p, 1);
                chk("ready_u", w_ready_u, 1);
                chk("latency", cyc - e.k, e.lat);
                chk("rdata_p", w_rdata_p, e.rd_p);
                chk("rdata_u", w_rdata_u, e.rd_u);
                chk("page_p", w_page_p, e.page);
                chk("page_u", w_page_u, e.page);
            end
        end
    end

    always @(negedge clk) begin
        op_t o;
        if (!w_cs_p) chk("idle_strobes_p", {w_read_p, w_rw_p}, 2'b01);
        if (!w_cs_u) chk("idle_strobes_u", {w_read_u, w_rw_u}, 2'b01);
        if (w_cs_p || w_cs_u) begin
            if (op_q.size() == 0) begin
                chk("ram_unexpected", {30'd0, w_cs_p, w_cs_u}, 32'd0);
            end else begin
                o = op_q.pop_front();
                chk("ram_cs_p", w_cs_p, o.s_p);
                chk("ram_cs_u", w_cs_u, o.s_u);
                chk("ram_cycle", cyc, o.cyc);
                if (w_cs_p) begin
                    chk("ram_addr_p", w_addr_p, o.addr);
                    chk("ram_rw_p", w_rw_p, !o.wr);
                    chk("ram_read_p", w_read_p, !o.wr);
                    if (o.wr) chk("ram_wdata_p", w_wdata_p, o.wd);
                end
                if (w_cs_u) begin
                    chk("ram_addr_u", w_addr_u, o.addr);
                    chk("ram_rw_u", w_rw_u, !o.wr);
                    chk("ram_read_u", w_read_u, !o.wr);
                    if (o.wr) chk("ram_wdata_u", w_wdata_u, o.wd);
                end
            end
        end
    end

    // ------------------------------------------------------------------------
    // Driver: one CPU transaction. With b2b set, the call is made in the
    // negedge where the previous cpu_ready was seen, so cpu_vma stays high
    // through DONE and acceptance happens one edge later.
    // ------------------------------------------------------------------------
    task automatic do_txn(input bit [15:0] a, input bit rw, input bit [7:0] wd, input bit b2b);
        rsp_t      e;
        op_t       o;
        bit [18:0] p;
        bit        done;
        if (!b2b) @(negedge clk);
        r_cpu_addr  = a;
        r_cpu_rw    = rw;
        r_cpu_wdata = wd;
        r_cpu_vma   = 1'b1;
        e.k = b2b ? cyc + 1 : cyc;
        if (a == 16'hE6F0) begin
            if (rw) begin
                m_last_p = m_bank & 8'h87;
                m_last_u = m_bank & 8'h87;
            end else begin
                m_bank = wd & 8'h87;
            end
            e.lat = 1;
        end else begin
            p      = ref_phys(a);
            o.cyc  = e.k + 1;
            o.addr = p;
            o.wd   = wd;
            o.wr   = !rw;
            if (!rw) begin
                o.s_p = (a < 16'hE000);
                o.s_u = 1'b1;
                if (o.s_p) m_mem_p[int'(p)] = wd;
                m_mem_u[int'(p)] = wd;
                e.lat = 2;
            end else begin
                o.s_p = 1'b1;
                o.s_u = 1'b1;
                m_last_p = m_mem_p.exists(int'(p)) ? m_mem_p[int'(p)] : 8'h00;
                m_last_u = m_mem_u.exists(int'(p)) ? m_mem_u[int'(p)] : 8'h00;
                e.lat = 3;
            end
            op_q.push_back(o);
        end
        e.rd_p = m_last_p;
        e.rd_u = m_last_u;
        e.page = m_bank[2:0];
        rsp_q.push_back(e);
        done = 1'b0;
        for (int i = 0; i < c_TIMEOUT && !done; i++) begin
            @(negedge clk);
            if (w_ready_p || w_ready_u) done = 1'b1;
        end
        if (!done) chk("txn_timeout", {31'd0, done}, 32'd1);
        r_cpu_vma = 1'b0;
    endtask

    task automatic check_reset_values(input string tag);
        chk({tag, "_ctl_p"}, {w_ready_p, w_cs_p, w_read_p, w_rw_p, w_page_p}, 7'b0001_000);
        chk({tag, "_ctl_u"}, {w_ready_u, w_cs_u, w_read_u, w_rw_u, w_page_u}, 7'b0001_000);
        chk({tag, "_rdata_p"}, w_rdata_p, 0);
        chk({tag, "_rdata_u"}, w_rdata_u, 0);
        chk({tag, "_addr_p"}, w_addr_p, 0);
        chk({tag, "_addr_u"}, w_addr_u, 0);
        chk({tag, "_wdata_p"}, w_wdata_p, 0);
        chk({tag, "_wdata_u"}, w_wdata_u, 0);
    endtask

    // Start a read, then pull reset during RD_WAIT. The read's RAM cycle is
    // expected; its completion is not.
    task automatic reset_during_read(input bit [15:0] a);
        op_t o;
        @(negedge clk);
        r_cpu_addr = a;
        r_cpu_rw   = 1'b1;
        r_cpu_vma  = 1'b1;
        o.cyc  = cyc + 1;
        o.s_p  = 1'b1;
        o.s_u  = 1'b1;
        o.wr   = 1'b0;
        o.addr = ref_phys(a);
        o.wd   = 8'h00;
        op_q.push_back(o);
        @(posedge clk);          // accepted, entering RD_ISSUE
        #1 r_cpu_vma = 1'b0;
        @(posedge clk);          // entering RD_WAIT
        #2 rst_n = 1'b0;
        #1 check_reset_values("mid_read_reset");
        m_bank   = 8'h00;
        m_last_p = 8'h00;
        m_last_u = 8'h00;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    // ------------------------------------------------------------------------
    // Stimulus
    // ------------------------------------------------------------------------
    initial begin
        bit [15:0] a;
        bit        b2b;
        int        sel;
        rst_n       = 1'b1;
        r_cpu_addr  = 16'h0000;
        r_cpu_rw    = 1'b1;
        r_cpu_vma   = 1'b0;
        r_cpu_wdata = 8'h00;
        m_bank      = 8'h00;
        m_last_p    = 8'h00;
        m_last_u    = 8'h00;
        #1 rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check_reset_values("reset");
        rst_n = 1'b1;

        // Plain write then read of low memory.
        do_txn(16'h1234, 1'b0, 8'h5A, 1'b0);
        do_txn(16'h1234, 1'b1, 8'h00, 1'b0);
        // Window enabled, bank 3.
        do_txn(16'hE6F0, 1'b0, 8'h83, 1'b0);
        do_txn(16'hC005, 1'b0, 8'h77, 1'b0);
        do_txn(16'hC005, 1'b1, 8'h00, 1'b0);
        do_txn(16'hE6F0, 1'b1, 8'h00, 1'b0);
        // Window disabled: C005 maps straight through.
        do_txn(16'hE6F0, 1'b0, 8'h03, 1'b0);
        do_txn(16'hC005, 1'b1, 8'h00, 1'b0);
        do_txn(16'hC005, 1'b0, 8'h11, 1'b0);
        do_txn(16'hC005, 1'b1, 8'h00, 1'b0);
        // Unimplemented register bits read back as zero.
        do_txn(16'hE6F0, 1'b0, 8'hFF, 1'b0);
        do_txn(16'hE6F0, 1'b1, 8'h00, 1'b0);
        do_txn(16'hDFFF, 1'b0, 8'hC3, 1'b0);
        do_txn(16'hDFFF, 1'b1, 8'h00, 1'b0);
        // Protected top page.
        do_txn(16'hF000, 1'b0, 8'hFF, 1'b0);
        do_txn(16'hF000, 1'b1, 8'h00, 1'b0);
        // Reset in the middle of a read, then a normal read.
        reset_during_read(16'h1234);
        do_txn(16'h1234, 1'b1, 8'h00, 1'b0);
        // cpu_vma held through DONE.
        do_txn(16'h1234, 1'b1, 8'h00, 1'b0);
        do_txn(16'h1234, 1'b1, 8'h00, 1'b1);
        do_txn(16'hC005, 1'b1, 8'h00, 1'b1);
        do_txn(16'h2000, 1'b0, 8'h42, 1'b1);

        for (int i = 0; i < c_N_RANDOM; i++) begin
            sel = int'($urandom_range(0, 5));
            case (sel)
                0:       a = 16'h1200 + 16'($urandom_range(0, 15));
                1:       a = 16'hC000 + 16'($urandom_range(0, 15));
                2:       a = 16'hE6F0;
                3:       a = 16'hF000 + 16'($urandom_range(0, 15));
                4:       a = 16'hDFF8 + 16'($urandom_range(0, 7));
                default: a = 16'($urandom);
            endcase
            b2b = ($urandom_range(0, 3) == 0);
            do_txn(a, 1'($urandom_range(0, 1)), 8'($urandom), b2b);
        end

        repeat (4) @(negedge clk);
        chk("rsp_queue_empty", rsp_q.size(), 0);
        chk("op_queue_empty", op_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
        $fatal(1, "watchdog expired");
    end

endmodule

`default_nettype wire
